// File: rtl/map_rom_arbiter_pkg.sv
// map_arb_pkg: shared types for the map ROM arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default ROM address and word widths
//   arb_tag_t               : per-access tag carried alongside the ROM latency
//   owner_e                 : owner of the ROM slot in a given cycle
package map_arb_pkg;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 12;
   typedef struct packed {
      logic       valid;
      logic       is_draw;
      logic [2:0] idx;
   } arb_tag_t;
   typedef enum logic [1:0] {OWN_IDLE, OWN_DRAW, OWN_PROBE} owner_e;
endpackage

// File: rtl/map_rom_arbiter_rr_pick.sv
// rr_pick: NP-way round-robin priority picker.
//   i_req          : request vector
//   i_ptr          : index with highest priority this cycle
//   o_grant_onehot : one-hot grant
//   o_grant_idx    : index of the grant
//   o_any          : some request is granted
module rr_pick #(
   parameter int NP = 3
) (
   input  logic [NP-1:0] i_req,
   input  logic [2:0]    i_ptr,
   output logic [NP-1:0] o_grant_onehot,
   output logic [2:0]    o_grant_idx,
   output logic          o_any
);
   int w_j;
   always_comb begin
      o_grant_onehot = '0;
      o_grant_idx    = '0;
      o_any          = 1'b0;
      w_j            = 0;
      // walk from the farthest candidate back to i_ptr so the nearest requester is written last
      for (int k = NP - 1; k >= 0; k--) begin
         w_j = int'(i_ptr) + k;
         w_j = (w_j >= NP) ? w_j - NP : w_j;
         if (i_req[w_j]) begin
            o_grant_onehot      = '0;
            o_grant_onehot[w_j] = 1'b1;
            o_grant_idx         = 3'(w_j);
            o_any               = 1'b1;
         end
      end
   end
endmodule

// File: rtl/map_rom_arbiter.sv
// map_rom_arbiter: shares the single-port map ROM between the draw fetch and NP probes.
// Draw has top priority, probes share the remaining slots round-robin, and read data
// is steered back to its owner by a tag pipeline matched to the ROM latency.
// Optional starvation guard: define MAP_ARB_STARVE_GUARD_EN.
//   clk, rst                       : clock, synchronous active-high reset
//   i_draw_req/addr                : draw request and address
//   o_draw_rdata/rvalid            : draw return
//   i_probe_req/addr               : per-probe request, packed addresses
//   o_probe_ack                    : one-hot grant pulse
//   o_probe_rdata/rvalid           : shared probe data, one-hot return strobe
//   o_rom_addr / i_rom_data        : ROM interface
//   o_draw_miss                    : draw lost its slot to a starving probe
module map_rom_arbiter
   import map_arb_pkg::*;
#(
   parameter int NP           = 3,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int ROM_LAT      = 1,
   parameter int STARVE_LIMIT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_draw_req,
   input  logic [ADDR_W-1:0]    i_draw_addr,
   output logic [DATA_W-1:0]    o_draw_rdata,
   output logic                 o_draw_rvalid,
   input  logic [NP-1:0]        i_probe_req,
   input  logic [NP*ADDR_W-1:0] i_probe_addr,
   output logic [NP-1:0]        o_probe_ack,
   output logic [DATA_W-1:0]    o_probe_rdata,
   output logic [NP-1:0]        o_probe_rvalid,
   output logic [ADDR_W-1:0]    o_rom_addr,
   input  logic [DATA_W-1:0]    i_rom_data,
   output logic                 o_draw_miss
);
   logic [2:0]        r_rr_ptr;
   logic [ADDR_W-1:0] r_rom_addr;
   arb_tag_t          r_tag [ROM_LAT+1];
   logic [NP-1:0]     w_rr_onehot;
   logic [2:0]        w_rr_idx;
   logic              w_rr_any;
   logic              w_starve_any;
   logic [2:0]        w_starve_idx;
   owner_e            w_owner;
   logic [2:0]        w_idx;
   logic [ADDR_W-1:0] w_probe_addr;
   arb_tag_t          w_last;

   rr_pick #(.NP(NP)) u_pick (
      .i_req         (i_probe_req),
      .i_ptr         (r_rr_ptr),
      .o_grant_onehot(w_rr_onehot),
      .o_grant_idx   (w_rr_idx),
      .o_any         (w_rr_any)
   );

`ifdef MAP_ARB_STARVE_GUARD_EN
   logic [7:0] r_wait [NP];
   always_comb begin
      w_starve_any = 1'b0;
      w_starve_idx = '0;
      // descending scan leaves the lowest-index starving probe selected
      for (int i = NP - 1; i >= 0; i--) begin
         if (i_probe_req[i] && r_wait[i] >= 8'(STARVE_LIMIT)) begin
            w_starve_any = 1'b1;
            w_starve_idx = 3'(i);
         end
      end
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < NP; i++)
         r_wait[i] <= (rst || o_probe_ack[i]) ? 8'd0 :
                      (i_probe_req[i] && r_wait[i] != 8'hFF) ? r_wait[i] + 8'd1 : r_wait[i];
   end
   assign o_draw_miss = w_starve_any & i_draw_req & ~rst;
`else
   assign w_starve_any = 1'b0;
   assign w_starve_idx = '0;
   assign o_draw_miss  = 1'b0;
`endif

   always_comb begin
      w_owner      = rst          ? OWN_IDLE  :
                     w_starve_any ? OWN_PROBE :
                     i_draw_req   ? OWN_DRAW  :
                     w_rr_any     ? OWN_PROBE : OWN_IDLE;
      w_idx        = w_starve_any ? w_starve_idx : w_rr_idx;
      w_probe_addr = i_probe_addr[w_idx*ADDR_W +: ADDR_W];
      o_probe_ack  = '0;
      if (w_owner == OWN_PROBE) o_probe_ack[w_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr   <= '0;
         r_rom_addr <= '0;
         for (int s = 0; s <= ROM_LAT; s++) r_tag[s] <= '0;
      end else begin
         if (w_owner == OWN_PROBE) r_rr_ptr <= (w_idx == 3'(NP - 1)) ? 3'd0 : w_idx + 3'd1;
         if (w_owner == OWN_DRAW) r_rom_addr <= i_draw_addr;
         else if (w_owner == OWN_PROBE) r_rom_addr <= w_probe_addr;
         r_tag[0] <= '{valid: w_owner != OWN_IDLE, is_draw: w_owner == OWN_DRAW, idx: w_idx};
         for (int s = 1; s <= ROM_LAT; s++) r_tag[s] <= r_tag[s-1];
      end
   end

   // the last tag stage lines up with the cycle rom_data is valid
   always_comb begin
      w_last         = r_tag[ROM_LAT];
      o_probe_rvalid = '0;
      if (w_last.valid && !w_last.is_draw) o_probe_rvalid[w_last.idx] = 1'b1;
   end

   assign o_rom_addr    = r_rom_addr;
   assign o_draw_rvalid = w_last.valid & w_last.is_draw;
   assign o_draw_rdata  = i_rom_data;
   assign o_probe_rdata = i_rom_data;
endmodule
